// File: rtl/msg_pkg.sv
// Shared constants and types for the message block builder: block geometry,
// MD5-style padding constants and the 64-byte working buffer type.
package msg_pkg;

   localparam int         MSG_BYTES     = 64;
   localparam int         LEN_FIELD_POS = 56;
   localparam logic [7:0] PAD_BYTE      = 8'h80;
   localparam int         MAX_LEN       = 55;

   // Byte i of the buffer lands in bits [8i+7:8i] when viewed as a 512-bit block
   typedef logic [MSG_BYTES-1:0][7:0] msg_buf_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } blk_state_e;

   function automatic logic [5:0] clamp_len(input logic [5:0] len, input logic [5:0] max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/msg_block_builder_if.sv
// Update-beat and output-block handshake bundle between char_gen, the
// message block builder and the hash core.
interface msg_block_builder_if;
   import msg_pkg::*;

   logic                     upd_valid;
   logic                     upd_ready;
   logic [5:0]               upd_offset;
   logic [6:0]               upd_index;
   logic                     upd_commit;
   logic [5:0]               upd_len;
   logic [63:0]              upd_counter;

   logic                     blk_valid;
   logic                     blk_ready;
   logic [MSG_BYTES*8-1:0]   blk_data;
   logic [63:0]              blk_counter;

   // The builder's view
   modport slave (
      input  upd_valid, upd_offset, upd_index, upd_commit, upd_len, upd_counter, blk_ready,
      output upd_ready, blk_valid, blk_data, blk_counter
   );

   // The environment's view (char_gen side and hash-core side together)
   modport master (
      output upd_valid, upd_offset, upd_index, upd_commit, upd_len, upd_counter, blk_ready,
      input  upd_ready, blk_valid, blk_data, blk_counter
   );

endinterface

// File: rtl/msg_pad.sv
// Combinational padder: message bytes 0..L-1, 0x80 at L, zeros, then L*8 as a
// 64-bit length field. MSG_BLOCK_BUILDER_BE_LEN_EN selects a big-endian length field.
module msg_pad
   import msg_pkg::*;
(
   input  msg_buf_t              wbuf,
   input  logic [5:0]            len,
   output logic [MSG_BYTES*8-1:0] block
);

   msg_buf_t    blk;
   logic [63:0] bit_len;
   int          len_i;

   // NOTE: every variable written here gets a default first so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      blk     = '0;
      len_i   = int'(len);
      bit_len = {55'd0, len, 3'd0};
      for (int i = 0; i < LEN_FIELD_POS; i++) begin
         if (i < len_i) begin
            blk[i] = wbuf[i];
         end else if (i == len_i) begin
            blk[i] = PAD_BYTE;
         end
      end
      for (int j = 0; j < 8; j++) begin
`ifdef MSG_BLOCK_BUILDER_BE_LEN_EN
         blk[LEN_FIELD_POS + j] = bit_len[8*(7-j) +: 8];
`else
         blk[LEN_FIELD_POS + j] = bit_len[8*j +: 8];
`endif
      end
   end

   assign block = blk;

endmodule

// File: rtl/msg_block_builder.sv
// Applies char_gen character updates to a prefix-bearing working buffer and
// emits a padded 512-bit block per committed word. Length-field endianness: MSG_BLOCK_BUILDER_BE_LEN_EN.
module msg_block_builder
   import msg_pkg::*;
#(
   parameter int MAX_LEN  = 55,
   parameter int CS_DEPTH = 128
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cs_we,
   input  logic [6:0]           cs_addr,
   input  logic [7:0]           cs_data,
   input  logic                 pre_we,
   input  logic [5:0]           pre_addr,
   input  logic [7:0]           pre_data,
   msg_block_builder_if.slave   bus,
   output logic                 len_err
);

   localparam logic [5:0] MAX_LEN_W  = 6'(MAX_LEN);
   localparam logic [5:0] DATA_LIMIT = 6'(LEN_FIELD_POS);

   logic [CS_DEPTH-1:0][7:0] cs_q, cs_d;
   msg_buf_t                 wbuf_q, wbuf_d;
   blk_state_e               state_q, state_d;
   logic [MSG_BYTES*8-1:0]   blk_data_q, blk_data_d;
   logic [63:0]              blk_counter_q, blk_counter_d;
   logic                     len_err_q, len_err_d;

   logic                     upd_acc;
   logic                     commit_acc;
   logic                     len_over;
   logic [5:0]               len_eff;
   logic [7:0]               upd_char;
   logic [MSG_BYTES*8-1:0]   padded;

   assign bus.upd_ready = (state_q == ST_EMPTY) || bus.blk_ready;
   assign upd_acc       = bus.upd_valid && bus.upd_ready;
   assign commit_acc    = upd_acc && bus.upd_commit;
   assign len_over      = bus.upd_len > MAX_LEN_W;
   assign len_eff       = clamp_len(bus.upd_len, MAX_LEN_W);

   // Lookup reads the registered table, so a same-cycle write is seen only from the next cycle
   assign upd_char = cs_q[bus.upd_index];

   always_comb begin
      cs_d = cs_q;
      if (cs_we) begin
         cs_d[cs_addr] = cs_data;
      end
   end

   // Update is applied after the prefix write so it wins on an address collision
   always_comb begin
      wbuf_d = wbuf_q;
      if (pre_we) begin
         wbuf_d[pre_addr] = pre_data;
      end
      if (upd_acc && (bus.upd_offset < DATA_LIMIT)) begin
         wbuf_d[bus.upd_offset] = upd_char;
      end
   end

   // Padding sees the next-state buffer so the commit beat's own character is included
   msg_pad u_pad (
      .wbuf  (wbuf_d),
      .len   (len_eff),
      .block (padded)
   );

   always_comb begin
      state_d       = state_q;
      blk_data_d    = blk_data_q;
      blk_counter_d = blk_counter_q;
      len_err_d     = len_err_q;
      case (state_q)
         ST_EMPTY: if (commit_acc) state_d = ST_FULL;
         ST_FULL:  if (bus.blk_ready && !commit_acc) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
      if (commit_acc) begin
         blk_data_d    = padded;
         blk_counter_d = bus.upd_counter;
         if (len_over) begin
            len_err_d = 1'b1;
         end
      end
   end

   // NOTE: register updates use <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the charset table and working buffer are flop arrays that must read as zero after reset, so they are reset like any other state.
         cs_q          <= '0;
         wbuf_q        <= '0;
         state_q       <= ST_EMPTY;
         blk_data_q    <= '0;
         blk_counter_q <= '0;
         len_err_q     <= 1'b0;
      end else begin
         cs_q          <= cs_d;
         wbuf_q        <= wbuf_d;
         state_q       <= state_d;
         blk_data_q    <= blk_data_d;
         blk_counter_q <= blk_counter_d;
         len_err_q     <= len_err_d;
      end
   end

   assign bus.blk_valid   = (state_q == ST_FULL);
   assign bus.blk_data    = blk_data_q;
   assign bus.blk_counter = blk_counter_q;
   assign len_err         = len_err_q;

endmodule

// File: tb/tb_msg_block_builder.sv
// Bench for msg_block_builder: directed vector table, reset-while-full sequence
// and a randomized phase, all checked against an array-based reference model.
module tb_msg_block_builder;

`ifdef MSG_BLOCK_BUILDER_BE_LEN_EN
   localparam int LEN_LSB = 63;
   localparam int LEN_B1  = 62;
`else
   localparam int LEN_LSB = 56;
   localparam int LEN_B1  = 57;
`endif

   typedef struct {
      bit          cs_we;
      bit [6:0]    cs_addr;
      bit [7:0]    cs_data;
      bit          pre_we;
      bit [5:0]    pre_addr;
      bit [7:0]    pre_data;
      bit          upd_valid;
      bit [5:0]    upd_offset;
      bit [6:0]    upd_index;
      bit          upd_commit;
      bit [5:0]    upd_len;
      bit [63:0]   upd_counter;
      bit          blk_ready;
      bit          e_valid;
      bit          e_rdy;
      bit          e_err;
      bit [63:0]   e_cnt;
      int          chk_byte;
      bit [7:0]    e_byte;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic cs_we, pre_we, len_err;
   logic [6:0] cs_addr;
   logic [7:0] cs_data, pre_data;
   logic [5:0] pre_addr;

   msg_block_builder_if bus ();

   msg_block_builder dut (
      .clk      (clk),
      .reset    (reset),
      .cs_we    (cs_we),
      .cs_addr  (cs_addr),
      .cs_data  (cs_data),
      .pre_we   (pre_we),
      .pre_addr (pre_addr),
      .pre_data (pre_data),
      .bus      (bus.slave),
      .len_err  (len_err)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit [7:0]   m_cs [128];
   bit [7:0]   m_wb [64];
   bit         m_valid, m_err;
   bit [511:0] m_data;
   bit [63:0]  m_cnt;
   bit         pre_rdy;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t tbl[$];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      foreach (m_cs[i]) m_cs[i] = 8'h00;
      foreach (m_wb[i]) m_wb[i] = 8'h00;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_data  = '0;
      m_cnt   = '0;
   endfunction

   // Padded block straight from the rules: data, 0x80, zeros, bit length
   function automatic bit [511:0] build(input int len);
      bit [7:0]   b [64];
      bit [63:0]  bits;
      bit [511:0] r;
      int         l;
      l = (len > 55) ? 55 : len;
      foreach (b[i]) b[i] = 8'h00;
      for (int i = 0; i < l; i++) b[i] = m_wb[i];
      b[l] = 8'h80;
      bits = 64'(l) * 64'd8;
      for (int j = 0; j < 8; j++) begin
`ifdef MSG_BLOCK_BUILDER_BE_LEN_EN
         b[63 - j] = bits[8*j +: 8];
`else
         b[56 + j] = bits[8*j +: 8];
`endif
      end
      for (int i = 0; i < 64; i++) r[8*i +: 8] = b[i];
      return r;
   endfunction

   function automatic vec_t s_idle(input bit brdy);
      vec_t t;
      t = '{default: 0};
      t.chk_byte  = -1;
      t.blk_ready = brdy;
      return t;
   endfunction

   function automatic vec_t s_upd(input int off, input int idx, input bit com, input int len,
                                  input int cnt, input bit brdy);
      vec_t t;
      t = s_idle(brdy);
      t.upd_valid   = 1'b1;
      t.upd_offset  = 6'(off);
      t.upd_index   = 7'(idx);
      t.upd_commit  = com;
      t.upd_len     = 6'(len);
      t.upd_counter = 64'(cnt);
      return t;
   endfunction

   function automatic void add(input vec_t t, input bit ev, input bit er, input bit ee,
                               input int ec, input int cb, input bit [7:0] eb);
      t.e_valid  = ev;
      t.e_rdy    = er;
      t.e_err    = ee;
      t.e_cnt    = 64'(ec);
      t.chk_byte = cb;
      t.e_byte   = eb;
      tbl.push_back(t);
   endfunction

   task automatic drive(input vec_t v);
      cs_we           = v.cs_we;
      cs_addr         = v.cs_addr;
      cs_data         = v.cs_data;
      pre_we          = v.pre_we;
      pre_addr        = v.pre_addr;
      pre_data        = v.pre_data;
      bus.upd_valid   = v.upd_valid;
      bus.upd_offset  = v.upd_offset;
      bus.upd_index   = v.upd_index;
      bus.upd_commit  = v.upd_commit;
      bus.upd_len     = v.upd_len;
      bus.upd_counter = v.upd_counter;
      bus.blk_ready   = v.blk_ready;
   endtask

   // One clock: drive, check combinational ready, advance model, check registered outputs
   task automatic apply(input vec_t v, input string tag);
      bit       acc, exp_rdy;
      bit [7:0] ch;
      drive(v);
      #1;
      exp_rdy = !m_valid || v.blk_ready;
      pre_rdy = bus.upd_ready;
      check({tag, " upd_ready"}, 512'(bus.upd_ready), 512'(exp_rdy));
      acc = v.upd_valid && exp_rdy;
      ch  = m_cs[v.upd_index];
      if (v.cs_we) m_cs[v.cs_addr] = v.cs_data;
      if (v.pre_we) m_wb[v.pre_addr] = v.pre_data;
      if (acc && v.upd_offset < 56) m_wb[v.upd_offset] = ch;
      if (acc && v.upd_commit) begin
         m_valid = 1'b1;
         m_data  = build(int'(v.upd_len));
         m_cnt   = v.upd_counter;
         if (v.upd_len > 55) m_err = 1'b1;
      end else if (v.blk_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check({tag, " blk_valid"},   512'(bus.blk_valid),   512'(m_valid));
      check({tag, " len_err"},     512'(len_err),         512'(m_err));
      check({tag, " blk_counter"}, 512'(bus.blk_counter), 512'(m_cnt));
      check({tag, " blk_data"},    bus.blk_data,          m_data);
   endtask

   task automatic do_reset(input int cycles);
      drive(s_idle(1'b0));
      reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t t;

      // Test 1: digits charset, two updates, commit len 2
      for (int i = 0; i < 10; i++) begin
         t = s_idle(1'b1); t.cs_we = 1'b1; t.cs_addr = 7'(i); t.cs_data = 8'(8'h30 + i);
         add(t, 0, 1, 0, 0, -1, 8'h00);
      end
      add(s_upd(0, 3, 0, 0, 0, 1'b1), 0, 1, 0, 0, -1, 8'h00);
      add(s_upd(1, 7, 1, 2, 5, 1'b0), 1, 1, 0, 5, 0, 8'h33);
      add(s_idle(1'b0), 1, 0, 0, 5, 1, 8'h37);
      add(s_idle(1'b0), 1, 0, 0, 5, 2, 8'h80);
      add(s_idle(1'b0), 1, 0, 0, 5, 3, 8'h00);
      add(s_idle(1'b0), 1, 0, 0, 5, LEN_LSB, 8'h10);
      add(s_idle(1'b1), 0, 1, 0, 0, -1, 8'h00);
      // Test 2: prefix "ab" reused across two commits
      t = s_idle(1'b1); t.pre_we = 1'b1; t.pre_addr = 6'd0; t.pre_data = 8'h61;
      add(t, 0, 1, 0, 0, -1, 8'h00);
      t = s_idle(1'b1); t.pre_we = 1'b1; t.pre_addr = 6'd1; t.pre_data = 8'h62;
      add(t, 0, 1, 0, 0, -1, 8'h00);
      add(s_upd(2, 1, 1, 3, 6, 1'b1), 1, 1, 0, 6, 0, 8'h61);
      add(s_upd(2, 2, 1, 3, 7, 1'b1), 1, 1, 0, 7, 2, 8'h32);
      add(s_idle(1'b0), 1, 0, 0, 7, 3, 8'h80);
      add(s_idle(1'b0), 1, 0, 0, 7, LEN_LSB, 8'h18);
      // Test 3: stalled commit, then released together with blk_ready
      add(s_upd(2, 5, 1, 3, 8, 1'b0), 1, 0, 0, 7, 2, 8'h32);
      add(s_upd(2, 5, 1, 3, 8, 1'b1), 1, 1, 0, 8, 2, 8'h35);
      add(s_idle(1'b1), 0, 1, 0, 0, -1, 8'h00);
      // Test 4: over-long commit clamps to 55 and sets sticky len_err
      add(s_upd(60, 0, 1, 60, 9, 1'b1), 1, 1, 1, 9, 55, 8'h80);
      add(s_idle(1'b0), 1, 0, 1, 9, LEN_LSB, 8'hB8);
      add(s_idle(1'b0), 1, 0, 1, 9, LEN_B1, 8'h01);
      add(s_idle(1'b1), 0, 1, 1, 0, -1, 8'h00);
      // Test 5: update beats prefix; lookup sees old charset value; L = 0
      t = s_upd(4, 9, 1, 6, 10, 1'b1); t.pre_we = 1'b1; t.pre_addr = 6'd4; t.pre_data = 8'h7A;
      add(t, 1, 1, 1, 10, 4, 8'h39);
      t = s_upd(5, 2, 1, 6, 11, 1'b1); t.cs_we = 1'b1; t.cs_addr = 7'd2; t.cs_data = 8'h58;
      add(t, 1, 1, 1, 11, 5, 8'h32);
      add(s_idle(1'b0), 1, 0, 1, 11, 6, 8'h80);
      add(s_upd(5, 2, 1, 6, 12, 1'b1), 1, 1, 1, 12, 5, 8'h58);
      add(s_upd(0, 0, 1, 0, 13, 1'b1), 1, 1, 1, 13, 0, 8'h80);
      add(s_idle(1'b0), 1, 0, 1, 13, LEN_LSB, 8'h00);
      add(s_idle(1'b1), 0, 1, 1, 0, -1, 8'h00);

      do_reset(2);
      check("reset blk_valid", 512'(bus.blk_valid), 512'(0));
      check("reset len_err", 512'(len_err), 512'(0));
      check("reset upd_ready", 512'(bus.upd_ready), 512'(1));
      check("reset blk_data", bus.blk_data, 512'(0));
      check("reset blk_counter", 512'(bus.blk_counter), 512'(0));

      for (int k = 0; k < tbl.size(); k++) begin
         string tag;
         tag = $sformatf("vec%0d", k);
         apply(tbl[k], tag);
         check({tag, " exp_rdy"},   512'(pre_rdy),       512'(tbl[k].e_rdy));
         check({tag, " exp_valid"}, 512'(bus.blk_valid), 512'(tbl[k].e_valid));
         check({tag, " exp_err"},   512'(len_err),       512'(tbl[k].e_err));
         if (tbl[k].e_valid)
            check({tag, " exp_cnt"}, 512'(bus.blk_counter), 512'(tbl[k].e_cnt));
         if (tbl[k].chk_byte >= 0)
            check({tag, " exp_byte"}, 512'(bus.blk_data[8*tbl[k].chk_byte +: 8]), 512'(tbl[k].e_byte));
      end

      // Test 6: reset while FULL drops the block and clears len_err and tables
      apply(s_upd(0, 1, 1, 60, 14, 1'b0), "pre_reset");
      check("pre_reset full", 512'(bus.blk_valid), 512'(1));
      do_reset(1);
      check("rst_full blk_valid", 512'(bus.blk_valid), 512'(0));
      check("rst_full len_err", 512'(len_err), 512'(0));
      apply(s_upd(0, 4, 1, 3, 15, 1'b1), "post_reset");
      check("post_reset byte0", 512'(bus.blk_data[7:0]), 512'(8'h00));
      check("post_reset byte3", 512'(bus.blk_data[31:24]), 512'(8'h80));
      check("post_reset lenfield", 512'(bus.blk_data[8*LEN_LSB +: 8]), 512'(8'h18));

      // Randomized phase against the model
      for (int n = 0; n < 600; n++) begin
         t = s_idle(1'($urandom_range(0, 1)));
         t.cs_we       = ($urandom_range(0, 3) == 0);
         t.cs_addr     = 7'($urandom_range(0, 127));
         t.cs_data     = 8'($urandom);
         t.pre_we      = ($urandom_range(0, 5) == 0);
         t.pre_addr    = 6'($urandom_range(0, 63));
         t.pre_data    = 8'($urandom);
         t.upd_valid   = ($urandom_range(0, 3) != 0);
         t.upd_offset  = 6'($urandom_range(0, 63));
         t.upd_index   = 7'($urandom_range(0, 127));
         t.upd_commit  = ($urandom_range(0, 2) == 0);
         t.upd_len     = 6'($urandom_range(0, 63));
         t.upd_counter = {32'($urandom), 32'($urandom)};
         apply(t, $sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/msg_block_builder.md
Name: msg_block_builder

Overview:
- Sits directly downstream of char_gen and upstream of the hash core.
- Consumes char_gen's per-beat character updates (byte offset plus charset index) and maps each index to ASCII through a loadable charset table.
- Applies each update to a 64-byte working message buffer that also holds a static prefix.
- On each word commit, emits a fully padded 512-bit hash block, tagged with its word counter, over a valid/ready handshake.

Parameters:
- MAX_LEN, 55, maximum message length in bytes that fits one padded block.
- CS_DEPTH, 128, charset table entries; matches the 7-bit index from char_gen.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cs_we  in  1  charset table write enable.
- cs_addr  in  7  charset table write index.
- cs_data  in  8  ASCII byte for that index.
- pre_we  in  1  prefix byte write enable, into the working buffer.
- pre_addr  in  6  prefix byte position.
- pre_data  in  8  prefix byte value.
- upd_valid  in  1  update beat valid.
- upd_ready  out  1  update beat accepted when upd_valid and upd_ready are both high.
- upd_offset  in  6  byte position being changed; from char_gen offset_out.
- upd_index  in  7  charset index; from char_gen msbyte_out.
- upd_commit  in  1  this beat completes a word.
- upd_len  in  6  total message length in bytes; sampled on a commit beat.
- upd_counter  in  64  word counter; sampled on a commit beat.
- blk_valid  out  1  output block valid.
- blk_ready  in  1  hash core accepts the block.
- blk_data  out  512  padded block; byte i is bits [8i+7:8i].
- blk_counter  out  64  counter of the word held in blk_data.
- len_err  out  1  sticky flag: a commit arrived with upd_len > MAX_LEN.

Behaviour:
- Reset:
  - charset table, working buffer, blk_data and blk_counter are cleared to 0.
  - blk_valid = 0, len_err = 0, upd_ready = 1.
  - Reset mid-handshake drops any held block without emitting it.
- Charset table:
  - 128x8 register array, written on cs_we.
  - Read combinationally by upd_index.
  - When cs_we and a lookup hit the same index in one cycle, the lookup returns the old value.
- Prefix write: on pre_we, wbuf[pre_addr] <= pre_data.
- Update write (accepted beat): wbuf[upd_offset] <= charset[upd_index].
  - If upd_offset >= 56, the write is ignored.
  - If the prefix write and the update write target the same address in one cycle, the update wins.
- Handshake: upd_ready = !blk_valid || blk_ready.
  - This is combinational; there is no back-to-back bubble.
  - Non-commit updates are also stalled by upd_ready.
- State machine:
  - EMPTY (blk_valid=0) -> FULL on an accepted commit.
  - FULL + blk_ready + accepted commit -> stays FULL with the new block.
  - FULL + blk_ready without a commit -> EMPTY.
  - FULL without blk_ready: blk_data and blk_counter hold stable.
- Block formation on an accepted commit, registered, so blk_valid rises the next cycle (1-cycle latency). Let L = min(upd_len, MAX_LEN):
  - bytes 0..L-1 come from wbuf, including that beat's own update.
  - byte L = 0x80.
  - bytes L+1..55 = 0x00.
  - bytes 56..63 = 64-bit bit length L*8, little-endian (MD5).
- Edge cases:
  - L = 0 gives byte 0 = 0x80 and a length field of 0.
  - upd_len > 55 sets len_err (sticky until reset) and the block is built with L = 55.
- wbuf is never cleared by a commit. Characters persist between words, so char_gen only sends changed positions.

Optional Feature:
- Macro: MSG_BLOCK_BUILDER_BE_LEN_EN.
- Defined: the length field in bytes 56..63 is big-endian (SHA-1/SHA-256 layout); byte 63 holds the least-significant length byte.
- Undefined: little-endian MD5 layout as described in Behaviour.
- Byte positions of message data are identical either way.

Decomposition:
- Shared package msg_pkg:
  - MSG_BYTES=64, LEN_FIELD_POS=56, PAD_BYTE=8'h80, MAX_LEN=55.
  - typedef for the 64x8 message buffer.
- Sub-module msg_pad: purely combinational; (wbuf, L) -> padded 512-bit block; endianness selected by the macro.

Test Plan:
1. Charset write idx0..9 = "0".."9"; updates offset0 idx3, offset1 idx7, commit len2 counter5 -> blk_data byte0=0x33, byte1=0x37, byte2=0x80, bytes3..55=0, byte56=0x10, blk_counter=5.
2. Prefix "ab" at 0..1; update offset2 idx1 (charset '1'), commit len3 -> bytes "ab1",0x80; byte56=0x18; second commit at offset2 idx2 reuses prefix -> "ab2".
3. Hold blk_ready=0 after a commit -> blk_valid stays 1, blk_data stable, upd_ready=0; raise blk_ready together with a new commit -> new block the next cycle with no idle cycle.
4. Commit with upd_len=60 -> len_err=1 and stays set; block has 0x80 at byte 55 and byte56=0xB8 (440).
5. Same-cycle pre_we and update to offset 4 -> byte 4 holds the charset value; cs_we to idx 2 while looking up idx 2 -> old ASCII is used.
6. Assert reset while FULL -> blk_valid=0 and len_err=0 the next cycle; a commit afterwards with an empty charset gives byte0=0x00, 0x80 at position L.
